// File: rtl/poly_fm_synth.sv
// Time-multiplexed two-operator FM synthesizer: per-voice modulator/carrier phase
// accumulators share one registered sine ROM; voice outputs are summed and saturated.
module poly_fm_synth #(
  parameter int N_VOICES = 4,
  parameter int FCW_W    = 24,
  parameter int SAMPLE_W = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_VOICES-1:0][FCW_W-1:0]    i_carrier_fcws,
  input  logic [N_VOICES-1:0][FCW_W-1:0]    i_mod_fcws,
  input  logic [N_VOICES-1:0][4:0]          i_mod_shifts,
  input  logic [N_VOICES-1:0]               i_note_en,
  output logic signed [SAMPLE_W-1:0]        o_sample,
  output logic                              o_sample_valid,
  input  logic                              i_sample_ready
);

  localparam int V_W    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int ACC_W  = SAMPLE_W + $clog2(N_VOICES) + 1;
  localparam int ADDR_W = 10;
  localparam int ROM_N  = 1 << ADDR_W;
  localparam logic [V_W-1:0] LAST_V = V_W'(N_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  // MOD_RD/MOD_CAP: modulator lookup; CAR_RD/CAR_CAP: carrier lookup + mix; OUT: saturate; WAIT: hold
  typedef enum logic [2:0] {
    S_MOD_RD, S_MOD_CAP, S_CAR_RD, S_CAR_CAP, S_OUT, S_WAIT
  } state_t;

  state_t r_state, w_state_nxt;

  logic [V_W-1:0]                    r_voice;
  logic [N_VOICES-1:0][FCW_W-1:0]    r_mod_phase;
  logic [N_VOICES-1:0][FCW_W-1:0]    r_car_phase;
  logic [N_VOICES-1:0]               r_en_d;
  logic signed [ACC_W-1:0]           r_acc;
  logic signed [SAMPLE_W-1:0]        r_m;
  logic signed [SAMPLE_W-1:0]        r_rom_q;

  logic                              w_en;
  logic                              w_note_on;
  logic [ADDR_W-1:0]                 w_rom_addr;
  logic [FCW_W-1:0]                  w_mod_term;
  logic [FCW_W-1:0]                  w_car_next;
  logic signed [ACC_W-1:0]           w_c_ext;
  logic signed [SAMPLE_W-1:0]        w_sat;

  function automatic logic signed [SAMPLE_W-1:0] sine_val(input int a);
    real x;
    x = (2.0 ** (SAMPLE_W - 1) - 1.0) * $sin(2.0 * 3.141592653589793 * $itor(a) / 1024.0);
    if (x >= 0.0) return SAMPLE_W'($rtoi(x + 0.5));
    return SAMPLE_W'(-$rtoi(0.5 - x));
  endfunction

  logic signed [SAMPLE_W-1:0] w_rom [ROM_N];
  for (genvar g = 0; g < ROM_N; g++) begin : g_rom
    assign w_rom[g] = sine_val(g);
  end

  always_ff @(posedge clk) begin
    r_rom_q <= w_rom[w_rom_addr];
  end

  assign w_en      = i_note_en[r_voice];
  assign w_note_on = w_en & ~r_en_d[r_voice];

  // A note-on pass reads the modulator from phase 0 before the cleared register lands.
  always_comb begin
    w_rom_addr = r_car_phase[r_voice][FCW_W-1 -: ADDR_W];
    if (r_state == S_MOD_RD)
      w_rom_addr = w_note_on ? '0 : r_mod_phase[r_voice][FCW_W-1 -: ADDR_W];
  end

  assign w_mod_term = {{(FCW_W - SAMPLE_W){r_m[SAMPLE_W-1]}}, r_m} << i_mod_shifts[r_voice];
  assign w_car_next = r_car_phase[r_voice] + i_carrier_fcws[r_voice] + w_mod_term;
  assign w_c_ext    = {{(ACC_W - SAMPLE_W){r_rom_q[SAMPLE_W-1]}}, r_rom_q};

  always_comb begin
    w_sat = r_acc[SAMPLE_W-1:0];
    if (r_acc > SAT_HI)      w_sat = SAT_HI[SAMPLE_W-1:0];
    else if (r_acc < SAT_LO) w_sat = SAT_LO[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_MOD_RD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_MOD_RD:  w_state_nxt = S_MOD_CAP;
      S_MOD_CAP: w_state_nxt = S_CAR_RD;
      S_CAR_RD:  w_state_nxt = S_CAR_CAP;
      S_CAR_CAP: w_state_nxt = (r_voice == LAST_V) ? S_OUT : S_MOD_RD;
      S_OUT:     w_state_nxt = S_WAIT;
      S_WAIT:    if (i_sample_ready) w_state_nxt = S_MOD_RD;
      default:   w_state_nxt = S_MOD_RD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_voice     <= '0;
      r_mod_phase <= '0;
      r_car_phase <= '0;
      r_en_d      <= '0;
      r_acc       <= '0;
      r_m         <= '0;
      o_sample    <= '0;
    end else begin
      case (r_state)
        S_MOD_RD: begin
          if (r_voice == '0) r_acc <= '0;
          if (w_note_on) begin
            r_mod_phase[r_voice] <= '0;
            r_car_phase[r_voice] <= '0;
          end
        end
        S_MOD_CAP: begin
          r_m <= r_rom_q;
          if (w_en) r_mod_phase[r_voice] <= r_mod_phase[r_voice] + i_mod_fcws[r_voice];
        end
        S_CAR_CAP: begin
          if (w_en) begin
            r_car_phase[r_voice] <= w_car_next;
            r_acc                <= r_acc + w_c_ext;
          end
          r_en_d[r_voice] <= w_en;
          if (r_voice != LAST_V) r_voice <= r_voice + 1'b1;
        end
        S_OUT:   o_sample <= w_sat;
        S_WAIT:  if (i_sample_ready) r_voice <= '0;
        default: ;
      endcase
    end
  end

  assign o_sample_valid = (r_state == S_WAIT);

endmodule

// File: tb/tb_poly_fm_synth.sv
// Randomized bench for poly_fm_synth: each emitted sample is compared with a
// pass-level arithmetic model of the voices, phases and saturating mix.
module tb_poly_fm_synth;
  localparam int N  = 4;
  localparam int FW = 24;
  localparam int SW = 14;
  localparam longint MASK = 64'h0000_0000_00FF_FFFF;
  localparam int LAT = 4 * N + 1;
  localparam int PER = 4 * N + 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N-1:0][FW-1:0]      cfcw;
  logic [N-1:0][FW-1:0]      mfcw;
  logic [N-1:0][4:0]         sh;
  logic [N-1:0]              en;
  logic signed [SW-1:0]      o_sample;
  logic                      o_sample_valid;
  logic                      ready;

  int n_tests = 0;
  int n_fail  = 0;

  int     rom_tab [1024];
  longint mp [N];
  longint cp [N];
  bit     en_d [N];

  poly_fm_synth dut (
    .clk            (clk),
    .rst            (rst),
    .i_carrier_fcws (cfcw),
    .i_mod_fcws     (mfcw),
    .i_mod_shifts   (sh),
    .i_note_en      (en),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .i_sample_ready (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rom_of(input longint ph);
    return rom_tab[int'((ph >> (FW - 10)) & 1023)];
  endfunction

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      mp[v] = 0;
      cp[v] = 0;
      en_d[v] = 0;
    end
  endtask

  task automatic model_pass(output longint exp);
    longint acc;
    int m, c;
    acc = 0;
    for (int v = 0; v < N; v++) begin
      if (en[v] && !en_d[v]) begin
        mp[v] = 0;
        cp[v] = 0;
      end
      m = rom_of(mp[v]);
      if (en[v]) mp[v] = (mp[v] + longint'(mfcw[v])) & MASK;
      c = rom_of(cp[v]);
      if (en[v]) begin
        cp[v] = (cp[v] + longint'(cfcw[v]) + (longint'(m) <<< sh[v])) & MASK;
        acc += c;
      end
      en_d[v] = en[v];
    end
    if (acc > 8191)       exp = 8191;
    else if (acc < -8192) exp = -8192;
    else                  exp = acc;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_sample_valid && cyc < 200);
    if (!o_sample_valid) chk("valid_timeout", o_sample_valid, 1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    int     lat;
    longint exp;
    longint s0;
    bit     sched [8];
    int     k;

    for (int i = 0; i < 1024; i++) begin
      real x;
      x = 8191.0 * $sin(2.0 * 3.141592653589793 * i / 1024.0);
      rom_tab[i] = (x < 0.0) ? -int'($floor(-x + 0.5)) : int'($floor(x + 0.5));
    end
    sched = '{1, 1, 0, 0, 1, 1, 0, 1};

    rst = 1'b1; ready = 1'b1; en = '0; cfcw = '0; mfcw = '0; sh = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", o_sample_valid, 0);
    chk("rst_sample", o_sample, 0);
    model_reset();
    rst = 1'b0;

    // all voices off
    for (int p = 0; p < 3; p++) begin
      wait_valid(lat);
      model_pass(exp);
      chk("off_lat", lat, (p == 0) ? LAT : PER);
      chk("off_sample", o_sample, exp);
    end

    // voice 0 stepping through the ROM one entry per sample
    en[0] = 1'b1;
    cfcw[0] = 24'(1 << 14);
    for (int p = 0; p < 6; p++) begin
      wait_valid(lat);
      model_pass(exp);
      chk("v0_model", o_sample, exp);
      chk("v0_rom", o_sample, rom_tab[p]);
    end

    // four voices a quarter cycle apart each pass: saturation
    en = '1;
    for (int v = 0; v < N; v++) cfcw[v] = 24'(1 << 22);
    reset_dut();
    wait_valid(lat);
    model_pass(exp);
    chk("quad_lat", lat, LAT);
    chk("quad_first", o_sample, 0);
    wait_valid(lat);
    model_pass(exp);
    chk("quad_second", o_sample, 8191);
    chk("quad_model", o_sample, exp);

    // backpressure: hold in WAIT for 20 cycles
    ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_valid", o_sample_valid, 1);
      chk("hold_sample", o_sample, exp);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    wait_valid(lat);
    model_pass(exp);
    chk("hold_resume_lat", lat + 1, PER);
    chk("hold_resume_sample", o_sample, exp);

    // random FM: voice 1 toggled off and back on, then random shifts and stalls
    for (int p = 0; p < 32; p++) begin
      for (int v = 0; v < N; v++) begin
        cfcw[v] = 24'($urandom);
        mfcw[v] = 24'($urandom);
        sh[v]   = (p < 8) ? 5'd10 : 5'($urandom_range(0, 31));
        en[v]   = 1'($urandom_range(0, 1));
      end
      if (p < 8) en[1] = sched[p];
      ready = 1'b1;
      wait_valid(lat);
      model_pass(exp);
      chk("fm_sample", o_sample, exp);
      k = $urandom_range(0, 2);
      if (k > 0) begin
        ready = 1'b0;
        repeat (k) begin
          @(negedge clk);
          chk("fm_stall_sample", o_sample, exp);
        end
      end
    end

    // reset pulse during voice 2 carrier capture
    ready = 1'b1;
    en = 4'b1111;
    for (int v = 0; v < N; v++) begin
      cfcw[v] = 24'($urandom);
      mfcw[v] = 24'($urandom);
      sh[v]   = 5'($urandom_range(0, 12));
    end
    reset_dut();
    wait_valid(lat);
    model_pass(exp);
    s0 = exp;
    chk("rstpulse_first", o_sample, exp);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rstpulse_midpass_valid", o_sample_valid, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstpulse_valid", o_sample_valid, 0);
    model_reset();
    rst = 1'b0;
    wait_valid(lat);
    model_pass(exp);
    chk("rstpulse_lat", lat, LAT);
    chk("rstpulse_repeat", o_sample, s0);
    chk("rstpulse_model", o_sample, exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
